// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the PC unit and the fetch/control logic.
// Carries op/target in, fetch address, link, EPC and RAS status out.
interface pc_unit_if #(
    parameter int AW = 32
);
    logic          stall;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic [AW-1:0] link;
    logic [AW-1:0] epc;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_underflow;
    logic          ras_overflow;
`ifdef PC_MISALIGN_TRAP_EN
    logic          misalign;
`endif

    modport master (
        output stall,
        output op,
        output target,
        input  pc,
        input  link,
        input  epc,
        input  ras_empty,
        input  ras_full,
        input  ras_underflow,
        input  ras_overflow
`ifdef PC_MISALIGN_TRAP_EN
        ,
        input  misalign
`endif
    );

    modport slave (
        input  stall,
        input  op,
        input  target,
        output pc,
        output link,
        output epc,
        output ras_empty,
        output ras_full,
        output ras_underflow,
        output ras_overflow
`ifdef PC_MISALIGN_TRAP_EN
        ,
        output misalign
`endif
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with return-address stack, EPC and link capture.
// Optional misaligned-target trap enabled by PC_MISALIGN_TRAP_EN.
module pc_unit #(
    parameter int            AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter logic [AW-1:0] EXC_VECTOR   = AW'('h80),
    parameter int            RAS_DEPTH    = 4
) (
    input logic       clk,
    input logic       rst_n,
    pc_unit_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] OP_SEQ     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_HOLD    = 3'd2;
    localparam logic [2:0] OP_RESTART = 3'd3;
    localparam logic [2:0] OP_CALL    = 3'd4;
    localparam logic [2:0] OP_RET     = 3'd5;
    localparam logic [2:0] OP_EXC     = 3'd6;
    localparam logic [2:0] OP_ERET    = 3'd7;

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] link_q, link_d;
    logic [AW-1:0] epc_q, epc_d;
    logic [PW-1:0] tp_q, tp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] ras_q [RAS_DEPTH];

    logic          push;
    logic          empty;
    logic          full;
    logic          trap;
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] ret_pc;
    logic [AW-1:0] sel;

`ifdef PC_MISALIGN_TRAP_EN
    logic          mis_q, mis_d;
`endif

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(RAS_DEPTH));
    assign seq_pc = pc_q + AW'(4);
    assign ret_pc = pc_q + AW'(8);

    // RET with an empty stack falls back to the supplied target
    assign sel = (bus.op == OP_RET && !empty) ? ras_q[tp_q] : bus.target;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap = (bus.op == OP_LOAD || bus.op == OP_CALL ||
                   bus.op == OP_RET) && (sel[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        pc_d   = pc_q;
        link_d = link_q;
        epc_d  = epc_q;
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = 1'b0;
        push   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        mis_d  = 1'b0;
`endif
        if (!bus.stall) begin
            unique case (bus.op)
                OP_SEQ: begin
                    pc_d = seq_pc;
                end
                OP_LOAD: begin
                    pc_d = sel;
                end
                OP_HOLD: begin
                    pc_d = pc_q;
                end
                OP_RESTART: begin
                    pc_d  = RESET_VECTOR;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
                OP_CALL: begin
                    pc_d = sel;
                    if (!trap) begin
                        link_d = ret_pc;
                        push   = 1'b1;
                        tp_d   = tp_q + PW'(1);
                        // full stack: newest overwrites oldest slot
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                OP_RET: begin
                    pc_d = sel;
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        tp_d  = tp_q - PW'(1);
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                OP_EXC: begin
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end
                OP_ERET: begin
                    pc_d = epc_q;
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
            if (trap) begin
                pc_d  = EXC_VECTOR;
                epc_d = sel;
`ifdef PC_MISALIGN_TRAP_EN
                mis_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_VECTOR;
            link_q <= '0;
            epc_q  <= '0;
            tp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            link_q <= link_d;
            epc_q  <= epc_d;
            tp_q   <= tp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push) begin
            ras_q[tp_d] <= ret_pc;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.misalign = mis_q;
`endif

    assign bus.pc            = pc_q;
    assign bus.link          = link_q;
    assign bus.epc           = epc_q;
    assign bus.ras_empty     = empty;
    assign bus.ras_full      = full;
    assign bus.ras_underflow = unf_q;
    assign bus.ras_overflow  = ovf_q;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; next generation of the core's PC register.
- Sits at the head of the fetch stage. Supplies the instruction-fetch address every cycle.
- Adds to the basic sequential/load/hold/restart set:
  - stall override
  - call/return with a hardware return-address stack (RAS)
  - exception entry/return with a saved EPC
  - link-address output for jal (PC+8)

Parameters:
- AW, 32: address width in bits; all address ports are AW wide.
- RESET_VECTOR, 0: PC value on reset and on op RESTART.
- EXC_VECTOR, 32'h0000_0080: PC value on exception entry.
- RAS_DEPTH, 4: return-address stack entries; a power of two, from 2 to 16.

Ports:
- clk in 1: rising-edge clock.
- rst_n in 1: asynchronous active-low reset.
- stall in 1: when 1, the cycle's op is ignored and all state holds.
- op in 3: operation code:
  - 0 SEQ
  - 1 LOAD
  - 2 HOLD
  - 3 RESTART
  - 4 CALL
  - 5 RET
  - 6 EXC
  - 7 ERET
- target in AW: jump/branch target, or fallback for RET.
- pc out AW: current fetch address (registered).
- link out AW: registered return address captured by the last CALL.
- epc out AW: PC saved by the last EXC.
- ras_empty out 1: RAS holds 0 entries.
- ras_full out 1: RAS holds RAS_DEPTH entries.
- ras_underflow out 1: 1-cycle pulse, RET executed with the RAS empty.
- ras_overflow out 1: sticky flag, a CALL pushed while the RAS was full; cleared only by reset or RESTART.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - pc=RESET_VECTOR; link=0; epc=0; RAS count=0.
  - ras_empty=1; ras_full=0; ras_underflow=0; ras_overflow=0.
- All updates happen on the rising edge of clk. pc changes 1 cycle after op is sampled. There are no combinational paths from inputs to outputs.
- stall=1 takes priority over every op: pc, link, epc and RAS are unchanged, and ras_underflow=0.
- SEQ: pc <= pc+4, mod 2^AW. Wrap-around from all-ones-minus-3 to 0 is legal and silent.
- LOAD: pc <= target.
- HOLD: pc unchanged.
- RESTART: pc <= RESET_VECTOR; RAS count <= 0; ras_overflow <= 0. epc and link are unchanged.
- CALL:
  - pc <= target; link <= pc+8 (mod 2^AW).
  - Push pc+8 onto the RAS.
  - If the RAS is full, the oldest entry is overwritten (circular buffer), count stays RAS_DEPTH, and ras_overflow <= 1.
- RET:
  - If the RAS is non-empty: pc <= top entry; count decrements.
  - If the RAS is empty: pc <= target; ras_underflow pulses 1 for one cycle; count stays 0.
- EXC: epc <= pc; pc <= EXC_VECTOR. The RAS is untouched.
- ERET: pc <= epc. epc is unchanged.
- Nested EXC overwrites epc; there is no EPC stack.
- RAS implementation:
  - Storage: RAS_DEPTH x AW register array with a top pointer of log2(RAS_DEPTH) bits and a count of log2(RAS_DEPTH)+1 bits.
  - ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are combinational from registered count only.
  - After an overflowing push, a later pop returns entries newest-first. After RAS_DEPTH pops the stack is empty, even though more pushes than that occurred.
- Illegal op encodings are not possible (3-bit code fully decoded).

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A LOAD, CALL or RET whose selected next-PC has bits [1:0] != 0 is converted into EXC.
  - epc <= the misaligned address (not pc); pc <= EXC_VECTOR.
  - A CALL converted this way performs no RAS push and no link update. A RET converted this way still pops the RAS.
  - Extra output misalign out 1: 1-cycle pulse in the cycle after the trap.
- Not defined: targets are used unmodified and there is no misalign port.

Test Plan:
1. Reset and sequencing:
   - Stimulus: rst_n low, then release; op=SEQ for 3 cycles.
   - Required: pc 0 -> 4 -> 8 -> 12. Asserting rst_n low mid-cycle forces pc=0 immediately, without waiting for a clock edge.
2. Stall priority:
   - Stimulus: pc=0x100, op=LOAD, target=0x200, stall=1 for 2 cycles, then stall=0.
   - Required: pc stays 0x100 for 2 cycles, then 0x200.
3. Call/return nesting:
   - Stimulus: from pc=0x10, CALL target=0x400; from 0x400, CALL target=0x800; then RET, RET.
   - Required:
     - After each CALL: link=0x18, then link=0x408.
     - RET sequence: pc 0x408, then pc 0x18, with ras_empty=1 at the end.
4. RAS overflow and underflow (RAS_DEPTH=4):
   - Stimulus: 5 CALLs with return addresses A1..A5, then 5 RETs with target=0xDEAD_BEE0.
   - Required:
     - ras_overflow=1 after the 5th CALL.
     - Pops return A5, A4, A3, A2.
     - The 5th RET gives pc=0xDEAD_BEE0 with a 1-cycle ras_underflow.
     - After that, RESTART clears ras_overflow and sets pc=0.
5. Exception round trip:
   - Stimulus: pc=0x2000, op=EXC, then ERET.
   - Required:
     - After EXC: epc=0x2000, pc=0x80.
     - After ERET: pc=0x2000.
     - RAS count unchanged throughout.
6. Wrap-around and misalign trap:
   - Stimulus (wrap): pc=0xFFFF_FFFC, SEQ.
   - Required (wrap): pc=0.
   - Stimulus (with PC_MISALIGN_TRAP_EN): LOAD target=0x302.
   - Required (trap): pc=0x80, epc=0x302, misalign pulses 1 cycle.
